// File: rtl/hog_svm_pkg.sv
// Shared widths, block geometry and FSM encoding for the HOG SVM window scorer.
// HOG_SVM_SAT_EN adds the saturating adder helper.
package hog_svm_pkg;

  localparam int FEA_I       = 4;
  localparam int FEA_F       = 28;
  localparam int W_I         = 4;
  localparam int W_F         = 12;
  localparam int FEA_W       = FEA_I + FEA_F;
  localparam int W_W         = W_I + W_F;
  localparam int ACC_FRAC    = FEA_F + W_F;
  localparam int LANES       = 9;
  localparam int PROD_W      = FEA_W + W_W + 1;
  localparam int DOT_W       = PROD_W + 4;
  localparam int N_BLK       = 105;
  localparam int GRP_PER_BLK = 4;
  localparam int BLK_W       = $clog2(N_BLK);
  localparam int W_ADDR_W    = 9;
  localparam int ACC_W       = 64;

  typedef logic [LANES*FEA_W-1:0] fea_grp_t;
  typedef logic [LANES*W_W-1:0]   w_grp_t;

  typedef enum logic [2:0] {IDLE, RD, DRAIN, ACC, EMIT} state_t;

`ifdef HOG_SVM_SAT_EN
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    s = a + b;
    // Overflow only when both operands share a sign the result lost.
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]))
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s;
  endfunction
`endif

endpackage

// File: rtl/hog_svm_window_score_if.sv
// Block-in / weight-read / score-out bundle of the window scorer.
interface hog_svm_window_score_if;
  import hog_svm_pkg::*;

  logic                    clear;
  fea_grp_t                fea_a;
  fea_grp_t                fea_b;
  fea_grp_t                fea_c;
  fea_grp_t                fea_d;
  logic                    i_valid;
  logic                    i_ready;
  logic                    w_rd;
  logic [W_ADDR_W-1:0]     w_addr;
  w_grp_t                  w_data;
  logic signed [ACC_W-1:0] bias;
  logic signed [ACC_W-1:0] score;
  logic                    detect;
  logic                    o_valid;

  modport master (
    output clear, fea_a, fea_b, fea_c, fea_d, i_valid, w_data, bias,
    input  i_ready, w_rd, w_addr, score, detect, o_valid
  );

  modport slave (
    input  clear, fea_a, fea_b, fea_c, fea_d, i_valid, w_data, bias,
    output i_ready, w_rd, w_addr, score, detect, o_valid
  );

endinterface

// File: rtl/hog_svm_window_score_svm_dot9.sv
// 9-lane signed dot product (unsigned feature x signed weight), registered sum.
// Latency 1 cycle; no backpressure, valid simply follows in_valid.
module svm_dot9
  import hog_svm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  fea_grp_t                fea,
  input  w_grp_t                  w,
  output logic                    out_valid,
  output logic signed [DOT_W-1:0] dot
);

  logic signed [DOT_W-1:0] sum;

  always_comb begin
    logic signed [PROD_W-1:0] p;
    p   = '0;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      // Zero-extend the feature so the product stays signed.
      p   = $signed({1'b0, fea[i*FEA_W +: FEA_W]}) * $signed(w[i*W_W +: W_W]);
      sum = sum + {{(DOT_W-PROD_W){p[PROD_W-1]}}, p};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      dot       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) dot <= sum;
    end
  end

endmodule

// File: rtl/hog_svm_window_score.sv
// Linear SVM window score: 4 serial groups/block, 6 cycles/block, o_valid T+7 after last block.
// i_ready low while a block is in flight. HOG_SVM_SAT_EN: saturating accumulate and bias add.
module hog_svm_window_score
  import hog_svm_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  hog_svm_window_score_if.slave bus
);

  localparam logic signed [ACC_W-1:0] ZERO = '0;

  state_t                  state, nxt;
  logic [1:0]              grp, g_d1;
  logic [BLK_W-1:0]        blk_idx;
  fea_grp_t                fea_q [GRP_PER_BLK];
  fea_grp_t                dot_fea;
  logic                    rd_d1, dot_in_vld, dot_vld;
  logic                    last_blk, accept;
  logic signed [DOT_W-1:0] dot;
  logic signed [ACC_W-1:0] dot_ext, acc, acc_next, score_now, score_q;
  logic                    detect_q;

  assign last_blk   = (blk_idx == BLK_W'(N_BLK - 1));
  assign accept     = bus.i_valid & bus.i_ready & ~bus.clear;
  assign dot_fea    = fea_q[g_d1];
  assign dot_in_vld = rd_d1 & ~bus.clear;
  assign dot_ext    = {{(ACC_W-DOT_W){dot[DOT_W-1]}}, dot};

`ifdef HOG_SVM_SAT_EN
  assign acc_next  = sat_add(acc, dot_ext);
  assign score_now = sat_add(acc, bus.bias);
`else
  assign acc_next  = acc + dot_ext;
  assign score_now = acc + bus.bias;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = RD;
      RD:      if (grp == 2'd3) nxt = DRAIN;
      DRAIN:   nxt = ACC;
      ACC:     nxt = last_blk ? EMIT : (accept ? RD : IDLE);
      EMIT:    nxt = accept ? RD : IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.clear) nxt = IDLE;
  end

  always_comb begin
    bus.i_ready = 1'b0;
    bus.w_rd    = 1'b0;
    bus.o_valid = 1'b0;
    bus.w_addr  = W_ADDR_W'(int'(blk_idx) * GRP_PER_BLK + int'(grp));
    bus.score   = score_q;
    bus.detect  = detect_q;
    unique case (state)
      IDLE:  bus.i_ready = 1'b1;
      RD:    bus.w_rd    = 1'b1;
      DRAIN: ;
      ACC:   bus.i_ready = ~last_blk;
      EMIT: begin
        bus.i_ready = 1'b1;
        bus.o_valid = ~bus.clear;
        bus.score   = score_now;
        bus.detect  = (score_now > ZERO);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fea_q[0] <= bus.fea_a;
      fea_q[1] <= bus.fea_b;
      fea_q[2] <= bus.fea_c;
      fea_q[3] <= bus.fea_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.clear) begin
      grp     <= '0;
      g_d1    <= '0;
      rd_d1   <= 1'b0;
      blk_idx <= '0;
      acc     <= '0;
    end else begin
      rd_d1 <= bus.w_rd;
      g_d1  <= grp;
      if (state == RD) grp <= grp + 2'd1;
      // Window restarts in the same cycle the score is presented.
      if (state == EMIT) begin
        acc     <= '0;
        blk_idx <= '0;
      end else begin
        if (dot_vld) acc <= acc_next;
        if (state == ACC && !last_blk) blk_idx <= blk_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      score_q  <= '0;
      detect_q <= 1'b0;
    end else if (bus.o_valid) begin
      score_q  <= score_now;
      detect_q <= (score_now > ZERO);
    end
  end

  svm_dot9 u_dot (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (dot_in_vld),
    .fea       (dot_fea),
    .w         (bus.w_data),
    .out_valid (dot_vld),
    .dot       (dot)
  );

endmodule

// File: doc/hog_svm_window_score.md
Name: hog_svm_window_score

Overview:
- Downstream consumer of the HOG feature generator; accepts one normalized 2x2-cell block per handshake as four 9-bin feature groups (fea_a..fea_d).
- Computes the linear SVM dot product against a weight memory, accumulates over all blocks of one detection window, adds bias, and emits a signed score plus a detect flag.
- Serial over the 4 groups with one 9-lane MAC, so it applies backpressure via i_ready.

Parameters:
- FEA_I, 4, integer bits of unsigned feature.
- FEA_F, 28, fractional bits of feature.
- W_I, 4, integer bits of signed weight (incl. sign).
- W_F, 12, fractional bits of weight.
- N_BLK, 105, blocks per window (7x15).
- W_ADDR_W, 9, weight memory address width (>= clog2(4*N_BLK)).
- ACC_W, 64, signed accumulator/score width, fraction FEA_F+W_F.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- clear  in  1  frame/window restart; aborts accumulation
- fea_a, fea_b, fea_c, fea_d  in  9*(FEA_I+FEA_F) each  block features, bin 0 at LSBs
- i_valid  in  1  block present
- i_ready  out  1  block accepted when i_valid & i_ready
- w_rd  out  1  weight read strobe
- w_addr  out  W_ADDR_W  weight group address = 4*blk_idx + g
- w_data  in  9*(W_I+W_F)  9 signed weights, valid one cycle after w_rd
- bias  in  ACC_W  signed bias, same fraction as accumulator, quasi-static
- score  out  ACC_W  signed window score
- detect  out  1  score > 0
- o_valid  out  1  one-cycle pulse, score/detect valid

Behaviour:
- Reset values: i_ready=1, w_rd=0, w_addr=0, score=0, detect=0, o_valid=0; acc=0, blk_idx=0, FSM=IDLE.
- FSM: IDLE -> RD (4 cycles, g=0..3) -> DRAIN -> ACC -> (EMIT if last block) -> IDLE.
- Accept at cycle T: latch all four groups; i_ready=0 from T+1.
- w_rd=1 on T+1..T+4 with w_addr = 4*blk_idx + 0..3; w_data arrives T+2..T+5.
- svm_dot9 registers each group dot product one cycle after its w_data arrives; acc adds each group on T+3..T+6.
- Non-last block: i_ready=1 again at T+6; blk_idx increments.
- Last block (blk_idx==N_BLK-1): o_valid=1 at T+7 with score=acc+bias and detect=(score>0, signed). i_ready=1 at T+7. acc and blk_idx reset to 0 in the same cycle.
- Arithmetic:
  - Feature zero-extended to FEA_I+FEA_F+1 signed bits; product is signed, FEA_I+FEA_F+W_I+W_F+1 bits.
  - 9-lane sum adds 4 guard bits; sign-extended to ACC_W before accumulation.
  - Without the optional feature, acc and score wrap two's-complement.
- i_valid while i_ready=0: ignored; no queueing. Upstream must hold the data.
- clear=1, any state: FSM to IDLE, acc=0, blk_idx=0, w_rd=0, o_valid=0 next cycle, i_ready=1 next cycle. A handshake in the same cycle as clear is dropped.
- clear has priority over EMIT; a window interrupted by clear never produces o_valid.
- rst mid-operation: all state returns to reset values next edge; no partial score emitted.

Optional Feature:
- HOG_SVM_SAT_EN defined: each accumulate and the bias add saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Undefined: wrap-around, and the saturation comparators are not synthesized.

Decomposition:
- Package hog_svm_pkg:
  - feature/weight/accumulator width localparams and fraction alignment constant (FEA_F+W_F);
  - N_BLK and groups-per-block (4);
  - FSM state enum (IDLE, RD, DRAIN, ACC, EMIT).
- Sub-module svm_dot9: 9 parallel signed multipliers plus registered adder tree, 1-cycle latency, valid in/out.

Test Plan:
- All features 0x1000_0000 (1.0), all weights 0x1000 (1.0), bias=-3780.0 (=-3780<<40): 105 blocks -> single o_valid, score=0, detect=0. Same stimulus with bias=-3779.0 -> score=1.0 (1<<40), detect=1.
- Hold i_valid continuously: check i_ready low exactly T+1..T+5 per block; w_addr sequence 0,1,2,3,4,5,6,7,...,419; o_valid at T+7 after block 104.
- Weights = address-dependent ramp (group g weight = g*2^-12), features 1.0: score matches golden model exactly.
- clear after 50 blocks, then 105 full blocks: exactly one o_valid, score identical to uninterrupted run; clear coincident with handshake drops that block.
- rst low at T+3 of block 60: outputs at reset values next cycle; a fresh 105-block window gives the correct score.
- Features 0xFFFF_FFFF, weights 0x8000, bias=-2^63:
  - HOG_SVM_SAT_EN defined: score=-2^63, detect=0.
  - HOG_SVM_SAT_EN undefined: score equals the wrapped sum.
